rca_operand_fifo: RTL and testbench

//  Operand staging buffer that feeds one data input (data_in/data_valid/data_in_ack) of a

---
 rtl/rca_operand_fifo.sv | 72 +++++++
 tb/tb_rca_operand_fifo.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/rca_operand_fifo.sv
// Operand staging FIFO in front of one PR-unit data input: buffers issue-side operands
// and holds the oldest entry on data_out until the PR unit acknowledges it.
module rca_operand_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  output logic [DATA_W-1:0]          data_out,
  output logic                       data_valid_out,
  input  logic                       data_in_ack,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       underflow_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic              push;
  logic              pop;
  logic              empty;

  // Handshake: a word transfers on the rising edge where valid and ready/ack are both high;
  // wr_ready and data_valid_out come only from registered count, so neither ack nor
  // wr_valid can combinationally affect the other side.
  assign empty          = (count == '0);
  assign wr_ready       = (count != FULL_CNT);
  assign data_valid_out = !empty;
  assign data_out       = empty ? '0 : mem[rd_ptr];
  assign push           = wr_valid & wr_ready;
  assign pop            = data_in_ack & data_valid_out;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      underflow_err <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
      if (data_in_ack && empty) begin
        underflow_err <= 1'b1;
      end
    end
  end

  // Storage is deliberately left untouched by rst/flush; empty masks stale contents.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_rca_operand_fifo.sv
// Bench for rca_operand_fifo: directed scenarios plus a random phase, checked against an
// expected-data queue and an occupancy/underflow model.
module tb_rca_operand_fifo;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int CW     = $clog2(DEPTH+1);

  logic              clk;
  logic              rst;
  logic              flush;
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] data_out;
  logic              data_valid_out;
  logic              data_in_ack;
  logic [CW-1:0]     count;
  logic              underflow_err;

  logic [DATA_W-1:0] exp_q[$];
  logic              exp_uf;
  int                n_checks;
  int                n_fail;

  rca_operand_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .wr_data        (wr_data),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .data_out       (data_out),
    .data_valid_out (data_valid_out),
    .data_in_ack    (data_in_ack),
    .count          (count),
    .underflow_err  (underflow_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: check registered outputs against the model, drive inputs, update the model.
  task automatic step(input bit r, input bit f, input bit wv, input logic [DATA_W-1:0] wd,
                      input bit ack);
    int sz;
    @(negedge clk);
    sz = exp_q.size();
    check_eq("count", 32'(count), 32'(sz));
    check_eq("data_valid_out", 32'(data_valid_out), 32'(sz != 0));
    check_eq("wr_ready", 32'(wr_ready), 32'(sz < DEPTH));
    check_eq("underflow_err", 32'(underflow_err), 32'(exp_uf));
    if (sz != 0) check_eq("head", data_out, exp_q[0]);
    else         check_eq("empty_data_out", data_out, 32'h0);
    rst         = r;
    flush       = f;
    wr_valid    = wv;
    wr_data     = wd;
    data_in_ack = ack;
    if (r || f) begin
      exp_q.delete();
      exp_uf = 1'b0;
    end else begin
      if (ack && sz == 0) exp_uf = 1'b1;
      if (ack && sz != 0) void'(exp_q.pop_front());
      if (wv && sz < DEPTH) exp_q.push_back(wd);
    end
  endtask

  task automatic idle();
    step(0, 0, 0, '0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1 && exp_q.size() != 0; i++) step(0, 0, 0, '0, 1);
    idle();
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    exp_uf      = 1'b0;
    rst         = 1'b1;
    flush       = 1'b0;
    wr_valid    = 1'b1;
    wr_data     = 32'hDEAD_BEEF;
    data_in_ack = 1'b0;
    @(posedge clk);
    // reset held two cycles with a write pending: nothing may be captured
    step(1, 0, 1, 32'hDEAD_BEEF, 0);
    step(1, 0, 1, 32'hDEAD_BEEF, 0);
    idle();
    idle();

    // fill, overfill attempt, drain in order
    step(0, 0, 1, 32'h11, 0);
    step(0, 0, 1, 32'h22, 0);
    step(0, 0, 1, 32'h33, 0);
    step(0, 0, 1, 32'h44, 0);
    step(0, 0, 1, 32'h55, 0);
    idle();
    for (int i = 0; i < 4; i++) step(0, 0, 0, '0, 1);
    idle();

    // streaming push/pop across pointer wrap, occupancy 1 in steady state
    for (int i = 0; i < 10; i++) step(0, 0, 1, 32'hA0 + i, i > 0);
    step(0, 0, 0, '0, 1);
    idle();

    // simultaneous push+pop at count 2, then at full
    step(0, 0, 1, 32'hB0, 0);
    step(0, 0, 1, 32'hB1, 0);
    step(0, 0, 1, 32'hB2, 1);
    idle();
    step(0, 0, 1, 32'hB3, 0);
    step(0, 0, 1, 32'hB4, 0);
    step(0, 0, 1, 32'hB5, 1);
    idle();
    drain();

    // head hold, then underflow and its stickiness
    step(0, 0, 1, 32'hC0, 0);
    for (int i = 0; i < 5; i++) idle();
    step(0, 0, 0, '0, 1);
    step(0, 0, 0, '0, 1);
    idle();
    step(0, 0, 1, 32'hC1, 0);
    drain();

    // flush mid-stream with push+pop in the flush cycle
    step(0, 0, 1, 32'hD0, 0);
    step(0, 0, 1, 32'hD1, 0);
    step(0, 0, 1, 32'hD2, 0);
    step(0, 1, 1, 32'hD3, 1);
    step(0, 0, 1, 32'h77, 0);
    idle();
    drain();

    // random traffic, occasional flush
    for (int i = 0; i < 300; i++) begin
      step(0, $urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0,
           DATA_W'($urandom()), $urandom_range(0, 2) == 0);
    end
    drain();
    step(1, 0, 0, '0, 0);
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
